accelbrot_com_word2block: RTL and testbench

Word-to-block deserializer. It is the receive-side counterpart of the block-to-word serializer on the engine's internal communication path. It collects a contiguous burst of NWORDS words, framed by a start marker, into one NWORDS*WWIDTH-bit block and presents that block with a single-cycle valid pulse. It also detects and flags framing faults: truncated bursts and words that arrive outside any burst.

---
 rtl/accelbrot_com_word2block.sv | 111 +++++++++++
 tb/tb_accelbrot_com_word2block.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/accelbrot_com_word2block.sv
// Word-to-block deserializer: gathers a start-framed burst of NWORDS words into
// one wide block, pulsing out_valid on completion and flagging framing faults.
module accelbrot_com_word2block #(
  parameter int unsigned NWORDS = 8,
  parameter int unsigned WWIDTH = 34
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [WWIDTH-1:0]        in,
  input  logic                     in_start,
  input  logic                     in_valid,
  output logic [NWORDS*WWIDTH-1:0] out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     err_short,
  output logic                     err_orphan
);

  localparam int unsigned BWIDTH = NWORDS * WWIDTH;
  localparam int unsigned CWIDTH = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam bit          SINGLE = (NWORDS == 1);

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  state_t              state;
  logic [CWIDTH-1:0]   cnt;
  logic [BWIDTH-1:0]   sr;
  logic [BWIDTH-1:0]   loaded_c;
  logic [BWIDTH-1:0]   shifted_c;
  logic                last_c;

  // New words always enter at the top slot; older words drift toward slot 0.
  always_comb begin
    loaded_c                     = '0;
    loaded_c[BWIDTH-1 -: WWIDTH] = in;
    shifted_c                    = sr >> WWIDTH;
    shifted_c[BWIDTH-1 -: WWIDTH] = in;
    last_c                       = (cnt == CWIDTH'(NWORDS - 1));
  end

  assign busy = (state == COLLECT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      sr         <= '0;
      out        <= '0;
      out_valid  <= 1'b0;
      err_short  <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      err_short  <= 1'b0;
      err_orphan <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_start) begin
            if (SINGLE) begin
              out       <= loaded_c;
              out_valid <= 1'b1;
              sr        <= '0;
              cnt       <= '0;
            end else begin
              sr    <= loaded_c;
              cnt   <= CWIDTH'(1);
              state <= COLLECT;
            end
          end else if (in_valid) begin
            err_orphan <= 1'b1;
          end
        end
        COLLECT: begin
          if (!in_valid) begin
            // Gap inside a burst: bursts must be contiguous.
            err_short <= 1'b1;
            sr        <= '0;
            cnt       <= '0;
            state     <= IDLE;
          end else if (in_start) begin
            // Restart: abandon partial block, this word becomes word 0.
            err_short <= 1'b1;
            if (SINGLE) begin
              out   <= loaded_c;
              sr    <= '0;
              cnt   <= '0;
              state <= IDLE;
            end else begin
              sr  <= loaded_c;
              cnt <= CWIDTH'(1);
            end
          end else if (last_c) begin
            out       <= shifted_c;
            out_valid <= 1'b1;
            sr        <= '0;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            sr  <= shifted_c;
            cnt <= cnt + CWIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accelbrot_com_word2block.sv
// Directed bench for accelbrot_com_word2block: an 8-word instance through the
// framing scenarios, plus a 1-word instance sharing the same input stream.
module tb_accelbrot_com_word2block;

  localparam int unsigned NW = 8;
  localparam int unsigned WW = 34;
  localparam int unsigned BW = NW * WW;

  logic          clk;
  logic          rstn;
  logic [WW-1:0] in;
  logic          in_start;
  logic          in_valid;
  logic [BW-1:0] out;
  logic          out_valid, busy, err_short, err_orphan;
  logic [WW-1:0] out1;
  logic          out_valid1, busy1, err_short1, err_orphan1;

  int checks = 0;
  int errors = 0;

  accelbrot_com_word2block #(.NWORDS(NW), .WWIDTH(WW)) u_dut (
    .clk(clk), .rstn(rstn), .in(in), .in_start(in_start), .in_valid(in_valid),
    .out(out), .out_valid(out_valid), .busy(busy),
    .err_short(err_short), .err_orphan(err_orphan)
  );

  accelbrot_com_word2block #(.NWORDS(1), .WWIDTH(WW)) u_dut1 (
    .clk(clk), .rstn(rstn), .in(in), .in_start(in_start), .in_valid(in_valid),
    .out(out1), .out_valid(out_valid1), .busy(busy1),
    .err_short(err_short1), .err_orphan(err_orphan1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Block whose slot k holds base+k.
  function automatic logic [BW-1:0] blk(input logic [WW-1:0] base);
    logic [BW-1:0] b;
    b = '0;
    for (int k = 0; k < NW; k++) b[k*WW +: WW] = base + WW'(k);
    return b;
  endfunction

  // Present one input cycle and return 1 time unit after the sampling edge.
  task automatic send(input logic [WW-1:0] w, input logic s, input logic v);
    in = w; in_start = s; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input string tag, input logic v, input logic b, input logic es, input logic eo);
    chk({tag, ".out_valid"}, BW'(out_valid), BW'(v));
    chk({tag, ".busy"}, BW'(busy), BW'(b));
    chk({tag, ".err_short"}, BW'(err_short), BW'(es));
    chk({tag, ".err_orphan"}, BW'(err_orphan), BW'(eo));
  endtask

  // Full burst base..base+7 with per-word flag checks; completion on the last.
  task automatic burst(input string tag, input logic [WW-1:0] base, input logic first_es);
    for (int k = 0; k < NW; k++) begin
      send(base + WW'(k), k == 0, 1'b1);
      if (k < NW - 1) flags(tag, 1'b0, 1'b1, (k == 0) && first_es, 1'b0);
    end
    flags({tag, ".done"}, 1'b1, 1'b0, 1'b0, 1'b0);
    chk({tag, ".out"}, out, blk(base));
  endtask

  initial begin
    in = '0; in_start = 1'b0; in_valid = 1'b0;
    rstn = 1'b0;
    #12;
    flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.out", out, '0);
    rstn = 1'b1;
    send('0, 1'b0, 1'b0);

    // 1: nominal
    burst("nominal", WW'(1), 1'b0);
    send('0, 1'b0, 1'b0);
    flags("nominal.after", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("nominal.hold", out, blk(WW'(1)));

    // 2: back-to-back
    burst("b2b_a", WW'(1), 1'b0);
    burst("b2b_b", WW'('h11), 1'b0);
    send('0, 1'b0, 1'b0);
    flags("b2b.after", 1'b0, 1'b0, 1'b0, 1'b0);

    // 3: short burst terminated by a gap
    for (int k = 0; k < 5; k++) send(WW'('h31 + k), k == 0, 1'b1);
    flags("short.pre", 1'b0, 1'b1, 1'b0, 1'b0);
    send('0, 1'b0, 1'b0);
    flags("short.gap", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("short.out_kept", out, blk(WW'('h11)));
    send('0, 1'b0, 1'b0);
    flags("short.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    burst("short.recover", WW'('h41), 1'b0);

    // 4: restart after 3 words
    for (int k = 0; k < 3; k++) send(WW'('h51 + k), k == 0, 1'b1);
    burst("restart", WW'('h21), 1'b1);

    // 5: orphan after completion
    send(WW'('h99), 1'b0, 1'b1);
    flags("orphan", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("orphan.out", out, blk(WW'('h21)));
    send('0, 1'b0, 1'b0);
    flags("orphan.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // 6: async reset mid-burst
    for (int k = 0; k < 4; k++) send(WW'('h61 + k), k == 0, 1'b1);
    flags("areset.pre", 1'b0, 1'b1, 1'b0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    flags("areset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("areset.out", out, '0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 4; k < NW; k++) begin
      send(WW'('h61 + k), 1'b0, 1'b1);
      flags("areset.orphan", 1'b0, 1'b0, 1'b0, 1'b1);
    end
    burst("areset.fresh", WW'('h71), 1'b0);
    send('0, 1'b0, 1'b0);

    // NWORDS=1: each start+valid completes immediately with out=in
    for (int k = 0; k < 3; k++) begin
      send(WW'('hA1 + k), 1'b1, 1'b1);
      chk("n1.out_valid", BW'(out_valid1), BW'(1'b1));
      chk("n1.out", BW'(out1), BW'(WW'('hA1 + k)));
      chk("n1.busy", BW'(busy1), BW'(1'b0));
      chk("n1.err_short", BW'(err_short1), BW'(1'b0));
    end
    send(WW'('hB0), 1'b0, 1'b1);
    chk("n1.orphan", BW'(err_orphan1), BW'(1'b1));
    chk("n1.orphan_nv", BW'(out_valid1), BW'(1'b0));
    chk("n1.out_kept", BW'(out1), BW'(WW'('hA3)));
    send('0, 1'b0, 1'b0);
    chk("n1.idle", BW'(out_valid1), BW'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
